// File: rtl/unified_mem_arbiter.sv
// Arbitrates a core's instruction-fetch and data ports onto one single-port memory.
// Data wins ties, an in-flight access is never pre-empted, and stalled accesses time out.
module unified_mem_arbiter #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    input  logic        d_rd,
    input  logic        d_wr,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] i_rdata,
    output logic        i_valid,
    output logic [31:0] d_rdata,
    output logic        d_valid,
    output logic        i_stall,
    output logic        d_stall,
    output logic        bus_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
);

    typedef enum logic [1:0] {IDLE, IFETCH, DACCESS, RESP} state_t;

    localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

    state_t     state;
    logic [7:0] wait_cnt;
    logic       timed_out;

    // This cycle is the TIMEOUT-th one spent waiting.
    assign timed_out = (wait_cnt >= TimeoutLast);

    assign i_stall = i_req & ~i_valid;
    assign d_stall = (d_rd | d_wr) & ~d_valid;

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            wait_cnt  <= 8'd0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
            i_rdata   <= 32'd0;
            d_rdata   <= 32'd0;
            i_valid   <= 1'b0;
            d_valid   <= 1'b0;
            bus_err   <= 1'b0;
        end else begin
            i_valid <= 1'b0;
            d_valid <= 1'b0;
            bus_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (d_rd | d_wr) begin
                        state     <= DACCESS;
                        wait_cnt  <= 8'd0;
                        mem_req   <= 1'b1;
                        mem_we    <= d_wr;
                        mem_addr  <= d_addr;
                        mem_wdata <= d_wdata;
                    end else if (i_req) begin
                        state    <= IFETCH;
                        wait_cnt <= 8'd0;
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= i_addr;
                    end
                end
                IFETCH, DACCESS: begin
                    if (mem_ready || timed_out) begin
                        state   <= RESP;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        bus_err <= ~mem_ready;
                        if (state == IFETCH) begin
                            i_valid <= 1'b1;
                            i_rdata <= mem_ready ? mem_rdata : 32'd0;
                        end else begin
                            d_valid <= 1'b1;
                            // Completed stores keep the last load value.
                            if (!mem_ready) begin
                                d_rdata <= 32'd0;
                            end else if (!mem_we) begin
                                d_rdata <= mem_rdata;
                            end
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter: a table of single transactions plus
// hand-written sequences for arbitration, non-pre-emption and mid-access reset.
module tb_unified_mem_arbiter;

    logic        clock, reset;
    logic        i_req, d_rd, d_wr;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        i_valid, d_valid, i_stall, d_stall, bus_err, mem_req, mem_we, mem_ready;

    unified_mem_arbiter #(.TIMEOUT(4)) dut (
        .clock(clock), .reset(reset),
        .i_req(i_req), .i_addr(i_addr),
        .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .i_rdata(i_rdata), .i_valid(i_valid), .d_rdata(d_rdata), .d_valid(d_valid),
        .i_stall(i_stall), .d_stall(d_stall), .bus_err(bus_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    // Memory model: ready after ws wait states (ws >= 255 means never).
    int          ws = 0;
    int          rcnt = 0;
    logic [31:0] rd_val = 32'd0;
    initial begin
        mem_ready = 1'b0;
        mem_rdata = 32'hBAD0BAD0;
    end
    always @(negedge clock) begin
        if (reset || !mem_req) begin
            rcnt      = 0;
            mem_ready = 1'b0;
        end else begin
            mem_ready = (rcnt == ws);
            rcnt++;
        end
        mem_rdata = mem_ready ? rd_val : 32'hBAD0BAD0;
    end

    // Monitor state, refreshed once per cycle by tick().
    int          cyc, nb, req_cycles, unstable, stall_bad, n_ival, n_dval, n_berr;
    int          ival_cyc, dval_cyc;
    logic        prev_req, last_ival, last_dval, err_at_valid;
    logic [31:0] burst_addr [4];
    logic        burst_we   [4];
    logic [31:0] b_addr, b_wd;
    logic        b_we;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic mon_clear();
        nb = 0; req_cycles = 0; unstable = 0; n_ival = 0; n_dval = 0; n_berr = 0;
        ival_cyc = 0; dval_cyc = 0; cyc = 0; err_at_valid = 1'b0;
    endtask

    // Observe at the falling edge, return just after the next rising edge.
    task automatic tick();
        @(negedge clock);
        cyc++;
        if (mem_req) begin
            req_cycles++;
            if (!prev_req) begin
                if (nb < 4) begin
                    burst_addr[nb] = mem_addr;
                    burst_we[nb]   = mem_we;
                end
                nb++;
                b_addr = mem_addr; b_we = mem_we; b_wd = mem_wdata;
            end else if (mem_addr !== b_addr || mem_we !== b_we || mem_wdata !== b_wd) begin
                unstable++;
            end
        end
        prev_req = mem_req;
        if (i_stall !== (i_req & ~i_valid)) stall_bad++;
        if (d_stall !== ((d_rd | d_wr) & ~d_valid)) stall_bad++;
        if (i_valid) begin n_ival++; ival_cyc = cyc; end
        if (d_valid) begin n_dval++; dval_cyc = cyc; end
        if (i_valid | d_valid) err_at_valid = bus_err;
        if (bus_err) n_berr++;
        last_ival = i_valid;
        last_dval = d_valid;
        @(posedge clock);
        #1;
    endtask

    typedef struct {
        logic [1:0]  kind;      // 0 fetch, 1 read, 2 write, 3 read+write
        logic [31:0] addr;
        logic [31:0] wdata;
        int          wst;
        logic [31:0] rdv;
        logic [31:0] exp_rdata;
        logic        exp_we;
        logic        exp_err;
        int          exp_lat;
        int          exp_reqc;
    } vec_t;

    task automatic run_vec(input int idx, input vec_t v);
        int lat;
        string tag;
        tag = $sformatf("vec%0d", idx);
        mon_clear();
        ws = v.wst;
        rd_val = v.rdv;
        if (v.kind == 2'd0) begin
            i_req = 1'b1; i_addr = v.addr;
        end else begin
            d_rd = (v.kind != 2'd2); d_wr = v.kind[1]; d_addr = v.addr; d_wdata = v.wdata;
        end
        lat = 0;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (last_ival || last_dval) begin
                lat = c;
                break;
            end
        end
        i_req = 1'b0; d_rd = 1'b0; d_wr = 1'b0;
        chk({tag, " latency"}, lat, v.exp_lat);
        chk({tag, " valid port"}, {n_ival[0], n_dval[0]}, (v.kind == 2'd0) ? 2'b10 : 2'b01);
        chk({tag, " rdata"}, (v.kind == 2'd0) ? i_rdata : d_rdata, v.exp_rdata);
        chk({tag, " bus_err"}, err_at_valid, v.exp_err);
        chk({tag, " req cycles"}, req_cycles, v.exp_reqc);
        chk({tag, " mem_addr"}, burst_addr[0], v.addr);
        chk({tag, " mem_we"}, burst_we[0], v.exp_we);
        if (v.exp_we) chk({tag, " mem_wdata"}, b_wd, v.wdata);
        chk({tag, " stable"}, unstable, 0);
        tick();
        chk({tag, " single pulse"}, n_ival + n_dval, 1);
        chk({tag, " idle req"}, prev_req, 1'b0);
    endtask

    vec_t vecs [8];

    initial begin
        vecs[0] = '{2'd0, 32'h100, 32'h0,        0,   32'h00500093, 32'h00500093, 1'b0, 1'b0, 3, 1};
        vecs[1] = '{2'd1, 32'h2000, 32'h0,       1,   32'h12345678, 32'h12345678, 1'b0, 1'b0, 4, 2};
        vecs[2] = '{2'd2, 32'h10, 32'hDEADBEEF,  3,   32'hFFFFFFFF, 32'h12345678, 1'b1, 1'b0, 6, 4};
        vecs[3] = '{2'd3, 32'h20, 32'hCAFEF00D,  0,   32'h11111111, 32'h12345678, 1'b1, 1'b0, 3, 1};
        vecs[4] = '{2'd1, 32'h30, 32'h0,         255, 32'h77777777, 32'h0,        1'b0, 1'b1, 6, 4};
        vecs[5] = '{2'd0, 32'h104, 32'h0,        2,   32'h00A00113, 32'h00A00113, 1'b0, 1'b0, 5, 3};
        vecs[6] = '{2'd0, 32'h108, 32'h0,        255, 32'h66666666, 32'h0,        1'b0, 1'b1, 6, 4};
        vecs[7] = '{2'd1, 32'h40, 32'h0,         3,   32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0, 1'b0, 6, 4};

        stall_bad = 0; prev_req = 1'b0;
        reset = 1'b1; i_req = 1'b0; d_rd = 1'b0; d_wr = 1'b0;
        i_addr = 32'd0; d_addr = 32'd0; d_wdata = 32'd0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst mem_req", mem_req, 1'b0);
        chk("rst mem_we", mem_we, 1'b0);
        chk("rst mem_addr", mem_addr, 32'd0);
        chk("rst mem_wdata", mem_wdata, 32'd0);
        chk("rst rdata", {i_rdata, d_rdata} == 64'd0, 1'b1);
        chk("rst pulses", {i_valid, d_valid, bus_err}, 3'b000);
        i_req = 1'b1; d_wr = 1'b1;
        #1;
        chk("rst stalls", {i_stall, d_stall}, 2'b11);
        i_req = 1'b0; d_wr = 1'b0;
        #1;
        chk("rst stalls idle", {i_stall, d_stall}, 2'b00);
        @(posedge clock);
        #1;
        reset = 1'b0;

        for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

        // Simultaneous fetch and load: data first, fetch follows.
        mon_clear();
        ws = 0; rd_val = 32'h00C00193;
        i_req = 1'b1; i_addr = 32'h104; d_rd = 1'b1; d_addr = 32'h2000;
        for (int c = 0; c < 30 && n_ival == 0; c++) begin
            tick();
            if (last_dval) d_rd = 1'b0;
            if (last_ival) i_req = 1'b0;
        end
        i_req = 1'b0; d_rd = 1'b0;
        chk("simul bursts", nb, 2);
        chk("simul first addr", burst_addr[0], 32'h2000);
        chk("simul second addr", burst_addr[1], 32'h104);
        chk("simul we", {burst_we[0], burst_we[1]}, 2'b00);
        chk("simul order", dval_cyc < ival_cyc, 1'b1);
        chk("simul valids", {n_dval[3:0], n_ival[3:0]}, 8'h11);
        chk("simul i_rdata", i_rdata, 32'h00C00193);
        chk("simul d_rdata", d_rdata, 32'h00C00193);

        // Load arrives while a fetch is waiting: fetch completes untouched first.
        mon_clear();
        ws = 3; rd_val = 32'h0000BEEF;
        i_req = 1'b1; i_addr = 32'h200;
        for (int c = 0; c < 40 && n_dval == 0; c++) begin
            tick();
            if (c == 2) begin d_rd = 1'b1; d_addr = 32'h300; end
            if (last_ival) i_req = 1'b0;
            if (last_dval) d_rd = 1'b0;
        end
        i_req = 1'b0; d_rd = 1'b0;
        chk("preempt bursts", nb, 2);
        chk("preempt first addr", burst_addr[0], 32'h200);
        chk("preempt second addr", burst_addr[1], 32'h300);
        chk("preempt req cycles", req_cycles, 8);
        chk("preempt stable", unstable, 0);
        chk("preempt order", ival_cyc < dval_cyc, 1'b1);
        chk("preempt valids", {n_dval[3:0], n_ival[3:0]}, 8'h11);
        chk("preempt d_rdata", d_rdata, 32'h0000BEEF);

        // Reset while a load waits on memory.
        mon_clear();
        ws = 255;
        d_rd = 1'b1; d_addr = 32'h50;
        repeat (3) tick();
        chk("mid req before reset", mem_req, 1'b1);
        reset = 1'b1; d_rd = 1'b0;
        tick();
        chk("mid rst mem_req", mem_req, 1'b0);
        chk("mid rst mem_addr", mem_addr, 32'd0);
        chk("mid rst rdata", {i_rdata, d_rdata} == 64'd0, 1'b1);
        reset = 1'b0;
        repeat (6) tick();
        chk("mid rst no valid", n_ival + n_dval, 0);
        chk("mid rst no bus_err", n_berr, 0);
        chk("mid rst idle", mem_req, 1'b0);

        run_vec(8, '{2'd1, 32'h60, 32'h0, 1, 32'h0BADF00D, 32'h0BADF00D, 1'b0, 1'b0, 4, 2});

        chk("stall tracking", stall_bad, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
